prog_mem_ctrl: RTL
==================

# prog_mem_ctrl

Parametrised, loadable program memory for the 8-bit processor, replacing the fixed 16x8 combinational ROM. It clears itself after reset and accepts a new program over a valid/ready load port. In the idle state it serves instruction fetches with a registered one-cycle read. It sits between the control unit's PC and the instruction decoder, with the load port driven by the boot/debug interface.

## Interface
- ADDR_W, default 4: PC/address width.
- DATA_W, default 8: instruction width.
- DEPTH, default 2**ADDR_W: number of words. Must be less than or equal to 2**ADDR_W.

- clk  input  1  Rising-edge clock; the only clock.
- rst  input  1  Synchronous, active-high reset.
- load_start  input  1  Single-cycle pulse that starts a program load. Honoured only in IDLE.
- load_valid  input  1  load_data is valid this cycle.
- load_last  input  1  Qualifies load_data as the final word of the load.
- load_data  input  DATA_W  Word to write.
- load_ready  output  1  Block accepts a word this cycle.
- load_done  output  1  One-cycle pulse when a load completes.
- load_count  output  ADDR_W+1  Number of words written by the last load.
- fetch_en  input  1  Fetch request that samples pc.
- pc  input  ADDR_W  Fetch address.
- instruction  output  DATA_W  Registered fetch data.
- instr_valid  output  1  instruction is the result of the previous cycle's fetch.
- busy  output  1  High in CLEAR and LOAD. Fetches are ignored while busy is high.

## Operation
- Storage: DEPTH x DATA_W register array, written only by the controller.
- States:
  - CLEAR: writes 0 to address clr_ptr each cycle, starting at 0. After address DEPTH-1 is written, goes to IDLE.
  - IDLE: serves fetches. load_start moves the block to LOAD and sets wr_ptr=0.
  - LOAD: load_ready=1. A handshake (load_valid & load_ready) writes load_data to mem[wr_ptr] and increments wr_ptr and load_count. A handshake with load_last=1, or the write to address DEPTH-1, ends the load: next state IDLE, load_ready deasserts at that edge, and load_done pulses for one cycle.
- Addresses not written by a load keep their prior contents. A load does not zero-fill.
- load_count resets to 0 at each load_start and holds its final value after the load.
- Fetch:
  - In IDLE, fetch_en=1 with pc at edge t gives instruction=mem[pc] and instr_valid=1 after edge t+1.
  - When no fetch is served, instr_valid=0 and instruction holds its last value.
  - fetch_en with pc >= DEPTH returns 0 with instr_valid=1.
- Simultaneous events:
  - load_start and fetch_en in the same IDLE cycle: the fetch is served and the state moves to LOAD.
  - load_start outside IDLE is ignored.
  - fetch_en in CLEAR or LOAD is ignored, giving instr_valid=0.
  - load_valid outside LOAD is ignored.
- Reset mid-operation: any state goes to CLEAR, aborts any load, and the full clear re-runs.

## Timing
- Reset values: state CLEAR, busy=1, load_ready=0, load_done=0, load_count=0, instruction=0, instr_valid=0, clr_ptr=0, wr_ptr=0.
- Clear: the first edge with rst=0 writes address 0. busy falls after DEPTH edges with rst=0, i.e. 16 cycles by default.
- Fetch latency: 1 cycle. Throughput: one fetch per cycle, back-to-back.
- Load throughput: one word per cycle while load_valid stays high.
- load_ready rises 1 cycle after load_start.
- load_done and busy=0 both appear 1 cycle after the final handshake. A new fetch may be issued in that same cycle.
- load_count is updated in the cycle after each handshake.

## Test plan
- Reset, then release: busy stays 1 for exactly 16 cycles. Then fetch pc=0..15 back-to-back → instruction=0x00 with instr_valid=1 one cycle after each request.
- load_start, then 16 consecutive words 0x10+i with load_last on i=15 → load_done pulses once, load_count=16, busy=0. Fetch pc=0..15 → 0x10..0x1F.
- Following the previous load, load 5 words 0xA0..0xA4 with last on the 5th → load_count=5. pc=0..4 return 0xA0..0xA4 and pc=5 returns 0x15.
- During LOAD, toggle load_valid (1,0,0,1,1) and assert fetch_en each cycle → only 3 words are written, instr_valid stays 0 throughout, and load_count=3 after last.
- Load 16 words without load_last, holding load_valid high for 20 cycles → load ends after the 16th word, load_ready=0, words 17-20 are dropped, and load_count=16.
- Assert rst after 3 words of a load → busy=1 for 16 cycles, load_count=0, and every pc reads 0x00.

Source files
------------

// File: rtl/prog_mem_ctrl.sv
// Loadable program memory: self-clears after reset, accepts a program over a
// valid/ready load port, and serves registered one-cycle instruction fetches.
module prog_mem_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              busy
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} state_t;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
  } fetch_rsp_t;

  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  fetch_rsp_t        rsp_q, rsp_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              hs;

  assign load_ready  = (state_q == S_LOAD);
  assign busy        = (state_q != S_IDLE);
  assign load_done   = done_q;
  assign load_count  = cnt_q;
  assign instruction = rsp_q.data;
  assign instr_valid = rsp_q.vld;
  assign hs          = load_ready & load_valid;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    rsp_d     = '{vld: 1'b0, data: rsp_q.data};
    mem_d     = mem_q;
    case (state_q)
      S_CLEAR: begin
        mem_d[clr_ptr_q] = '0;
        clr_ptr_d        = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LAST_A) begin
          state_d   = S_IDLE;
          clr_ptr_d = '0;
        end
      end
      S_IDLE: begin
        if (fetch_en) begin
          rsp_d.vld  = 1'b1;
          // Out-of-range addresses read as zero when DEPTH < 2**ADDR_W.
          rsp_d.data = ({1'b0, pc} < DEPTH_C) ? mem_q[pc] : '0;
        end
        if (load_start) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end
      S_LOAD: begin
        if (hs) begin
          mem_d[wr_ptr_q] = load_data;
          wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
          cnt_d           = cnt_q + (ADDR_W+1)'(1);
          if (load_last || wr_ptr_q == LAST_A) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      rsp_q     <= rsp_d;
    end
  end

  // Storage needs no reset: the CLEAR pass zeroes it before any fetch is served.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
